seg_disp_sched: RTL and testbench
=================================

Name: seg_disp_sched

Overview:
- Arbitrates ownership of the shared 4-digit 7-segment display between three requesters.
- Drives the seg_a..seg_d inputs of the 4-digit scan multiplexer.
- Requesters 0 and 1 share the display round-robin, each with a minimum dwell time.
- Requester 2 is an urgent/alert source: it preempts immediately and can be shown blinking.

Parameters:
- CLK_HZ, 12_000_000, clk frequency in Hz; the ms prescaler period is P = CLK_HZ/1000 cycles.
- DWELL_MS, 2000, minimum hold time in ms for requester 0/1 while the other one is requesting; range 1..65535.
- BLINK_HALF_MS, 250, urgent blink half-period in ms; 0 means no blink (steady display).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req  in  3  request level per requester; bit 2 is urgent
- pat0  in  32  requester 0 pattern; [31:24]=digit a, [23:16]=b, [15:8]=c, [7:0]=d
- pat1  in  32  requester 1 pattern, same layout as pat0
- pat2  in  32  requester 2 pattern, same layout as pat0
- gnt  out  3  one-hot current owner; 000 when idle
- gnt_chg  out  1  one-cycle pulse on every gnt change
- seg_a  out  8  digit a segments to the mux (1 = segment lit)
- seg_b  out  8  digit b segments to the mux
- seg_c  out  8  digit c segments to the mux
- seg_d  out  8  digit d segments to the mux

Behaviour:
- Reset values: state IDLE; gnt=000; gnt_chg=0; seg_a..seg_d=8'h00; last-served pointer=1, so requester 0 wins the first tie; prescaler, dwell_cnt and blink phase all 0.
- States and gnt encoding: IDLE (000), OWN0 (001), OWN1 (010), URG (100). gnt is a registered copy of the state.
- Next-state priority:
  1. req[2]=1 -> URG, from any state.
  2. Otherwise from IDLE or URG: pick among req[1:0]. A single requester wins. If both request, the one that is not the last-served pointer wins. If neither requests -> IDLE.
  3. OWNx with req[x]=0: re-arbitrate as in item 2 on the next edge; the other requester gets the display if it is requesting, else IDLE.
  4. OWNx with req[x]=1 and the other requester active: switch to the other owner on the edge after dwell_cnt==DWELL_MS; otherwise stay.
  5. OWNx with req[x]=1 and the other requester inactive: stay indefinitely.
- Pointer: updated to x on every entry into OWNx.
- Prescaler:
  - Counts 0..P-1 and asserts ms_tick at P-1.
  - Cleared to 0 on every state change.
  - dwell_cnt is cleared on entry to OWN0/OWN1, increments on ms_tick, and saturates at DWELL_MS.
  - Result: an owner facing contention holds the display exactly DWELL_MS*P+1 cycles.
- Blink:
  - Phase is cleared to "on" on entry to URG.
  - Phase toggles each time BLINK_HALF_MS ms ticks have elapsed in the phase.
  - Inactive when BLINK_HALF_MS=0.
- Output datapath, one-cycle registered:
  - Each cycle, seg_a..seg_d load the current owner's live pat fields.
  - In IDLE they load 8'h00. In URG with phase "off" they load 8'h00.
  - Pattern changes from the owner appear one cycle later.
  - Outputs update in the same cycle as gnt, so there is no mixed-owner frame.
- gnt_chg: 1 in exactly the cycle that gnt holds a new value.
- Preemption mid-dwell: the dwell of the interrupted owner is discarded. On URG exit, arbitration follows the pointer, so the interrupted owner only resumes if it is the rightful round-robin winner.
- Simultaneous events: req[2] rising in the same cycle as a dwell expiry -> URG wins. Owner dropping req in the same cycle the other requester rises -> switch to the other requester.
- Reset asserted mid-operation: all state and outputs return to reset values immediately, asynchronously.

Test Plan (CLK_HZ=4000, P=4, DWELL_MS=3, BLINK_HALF_MS=2):
- Reset with req=011 held -> gnt=000 and segs=00 during reset; first edge after release gives gnt=001, gnt_chg=1 for 1 cycle, seg_a..d = pat0 bytes (e.g. pat0=32'h3F065B4F -> 3F,06,5B,4F).
- req=011 held -> gnt alternates 001/010, each owner held 13 cycles; gnt_chg pulses on every switch.
- OWN0 owner with only req[0] for 100 cycles -> gnt stays 001 and gnt_chg stays 0; change pat0 -> segs follow 1 cycle later.
- req[2] rises at cycle 5 of OWN1 -> next edge gnt=100. Segs show pat2 for 8 cycles, then 00 for 8 cycles, repeating. Drop req[2] with req=011 -> gnt=001, since the pointer is 1.
- req[0] drops while in OWN0 with req[1]=0 -> next edge gnt=000, segs=00, gnt_chg=1.
- Assert rst mid-URG during blink "on" -> gnt, segs and gnt_chg are 0 immediately without waiting for a clock edge; after release, arbitration restarts from the pointer=1 state.

Source files
------------

// File: rtl/seg_disp_sched.sv
// Display ownership scheduler for a shared 4-digit 7-segment mux: round-robin
// between requesters 0/1 with a minimum dwell, plus a preempting blinking alert source.
module seg_disp_sched #(
    parameter int CLK_HZ        = 12_000_000,
    parameter int DWELL_MS      = 2000,
    parameter int BLINK_HALF_MS = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [31:0] pat0,
    input  logic [31:0] pat1,
    input  logic [31:0] pat2,
    output logic [2:0]  gnt,
    output logic        gnt_chg,
    output logic [7:0]  seg_a,
    output logic [7:0]  seg_b,
    output logic [7:0]  seg_c,
    output logic [7:0]  seg_d
);

    localparam int P  = CLK_HZ / 1000;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(P - 1);
    localparam logic [15:0]   DWELL_MAX  = 16'(DWELL_MS);
    localparam logic          BLINK_EN   = (BLINK_HALF_MS != 0);
    localparam logic [15:0]   BLINK_LAST = (BLINK_HALF_MS > 0) ? 16'(BLINK_HALF_MS - 1) : 16'd0;

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_OWN0 = 3'b001,
        S_OWN1 = 3'b010,
        S_URG  = 3'b100
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [15:0]     dwell_q, dwell_d;
    logic [15:0]     blink_cnt_q, blink_cnt_d;
    logic            phase_off_q, phase_off_d;
    logic            last_q, last_d;
    logic [2:0]      gnt_q;
    logic            gnt_chg_q;
    logic [31:0]     disp_q, disp_d;
    logic            ms_tick_s;
    logic            dwell_done_s;
    logic            state_chg_s;

    // Round-robin pick between requesters 0/1; last_one=1 means requester 1 was served last.
    function automatic state_e arbitrate(input logic [1:0] r, input logic last_one);
        state_e s;
        case (r)
            2'b01:   s = S_OWN0;
            2'b10:   s = S_OWN1;
            2'b11:   s = last_one ? S_OWN0 : S_OWN1;
            default: s = S_IDLE;
        endcase
        return s;
    endfunction

    assign ms_tick_s    = (presc_q == PRESC_LAST);
    assign dwell_done_s = (dwell_q == DWELL_MAX);
    assign state_chg_s  = (state_d != state_q);

    // Next-state selection: urgent preempts, otherwise dwell-limited round robin.
    always_comb begin
        state_d = state_q;
        if (req[2]) begin
            state_d = S_URG;
        end else begin
            case (state_q)
                S_OWN0: begin
                    if (!req[0]) begin
                        state_d = req[1] ? S_OWN1 : S_IDLE;
                    end else if (req[1] && dwell_done_s) begin
                        state_d = S_OWN1;
                    end else begin
                        state_d = S_OWN0;
                    end
                end
                S_OWN1: begin
                    if (!req[1]) begin
                        state_d = req[0] ? S_OWN0 : S_IDLE;
                    end else if (req[0] && dwell_done_s) begin
                        state_d = S_OWN0;
                    end else begin
                        state_d = S_OWN1;
                    end
                end
                S_IDLE, S_URG: state_d = arbitrate(req[1:0], last_q);
                default:       state_d = S_IDLE;
            endcase
        end
    end

    // Timebase, dwell, pointer and blink bookkeeping; all realign on any ownership change.
    always_comb begin
        presc_d     = presc_q;
        dwell_d     = dwell_q;
        blink_cnt_d = blink_cnt_q;
        phase_off_d = phase_off_q;
        last_d      = last_q;

        if (state_chg_s || ms_tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (state_chg_s && (state_d == S_OWN0 || state_d == S_OWN1)) begin
            dwell_d = 16'd0;
        end else if (ms_tick_s && !dwell_done_s) begin
            dwell_d = dwell_q + 16'd1;
        end else begin
            dwell_d = dwell_q;
        end

        if (state_chg_s && state_d == S_OWN0) begin
            last_d = 1'b0;
        end else if (state_chg_s && state_d == S_OWN1) begin
            last_d = 1'b1;
        end else begin
            last_d = last_q;
        end

        if (state_chg_s && state_d == S_URG) begin
            phase_off_d = 1'b0;
            blink_cnt_d = 16'd0;
        end else if (BLINK_EN && state_q == S_URG && ms_tick_s) begin
            if (blink_cnt_q == BLINK_LAST) begin
                phase_off_d = ~phase_off_q;
                blink_cnt_d = 16'd0;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
        end
    end

    // Segment data follows the next owner so grant and segments switch together.
    always_comb begin
        disp_d = 32'h0000_0000;
        case (state_d)
            S_OWN0:  disp_d = pat0;
            S_OWN1:  disp_d = pat1;
            S_URG:   disp_d = phase_off_d ? 32'h0000_0000 : pat2;
            default: disp_d = 32'h0000_0000;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            dwell_q     <= 16'd0;
            blink_cnt_q <= 16'd0;
            phase_off_q <= 1'b0;
            last_q      <= 1'b1;
            gnt_q       <= 3'b000;
            gnt_chg_q   <= 1'b0;
            disp_q      <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            dwell_q     <= dwell_d;
            blink_cnt_q <= blink_cnt_d;
            phase_off_q <= phase_off_d;
            last_q      <= last_d;
            gnt_q       <= state_d;
            gnt_chg_q   <= state_chg_s;
            disp_q      <= disp_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_chg = gnt_chg_q;
    assign seg_a   = disp_q[31:24];
    assign seg_b   = disp_q[23:16];
    assign seg_c   = disp_q[15:8];
    assign seg_d   = disp_q[7:0];

endmodule

// File: tb/tb_seg_disp_sched.sv
// Directed bench for seg_disp_sched with P=4, DWELL_MS=3, BLINK_HALF_MS=2.
module tb_seg_disp_sched;

    localparam logic [31:0] PAT0_A = 32'h3F06_5B4F;
    localparam logic [31:0] PAT0_B = 32'h666D_7D07;
    localparam logic [31:0] PAT1   = 32'h0606_3F3F;
    localparam logic [31:0] PAT2   = 32'h7950_505C;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [31:0] pat0, pat1, pat2;
    logic [2:0]  gnt;
    logic        gnt_chg;
    logic [7:0]  seg_a, seg_b, seg_c, seg_d;

    int checks = 0;
    int errors = 0;

    seg_disp_sched #(
        .CLK_HZ        (4000),
        .DWELL_MS      (3),
        .BLINK_HALF_MS (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .pat0    (pat0),
        .pat1    (pat1),
        .pat2    (pat2),
        .gnt     (gnt),
        .gnt_chg (gnt_chg),
        .seg_a   (seg_a),
        .seg_b   (seg_b),
        .seg_c   (seg_c),
        .seg_d   (seg_d)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] eg, input logic ec,
                             input logic [31:0] es);
        check_eq({tag, " gnt"},     32'(gnt),     32'(eg));
        check_eq({tag, " gnt_chg"}, 32'(gnt_chg), 32'(ec));
        check_eq({tag, " segs"},    {seg_a, seg_b, seg_c, seg_d}, es);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        req  = 3'b011;
        pat0 = PAT0_A;
        pat1 = PAT1;
        pat2 = PAT2;
        #1;
        check_out("reset", 3'b000, 1'b0, 32'h0);
        step();
        step();
        check_out("reset held", 3'b000, 1'b0, 32'h0);
        rst = 1'b0;

        step();
        check_out("first grant", 3'b001, 1'b1, PAT0_A);
        for (int k = 1; k <= 12; k++) begin
            step();
            check_out("own0 dwell", 3'b001, 1'b0, PAT0_A);
        end
        step();
        check_out("switch to 1", 3'b010, 1'b1, PAT1);
        for (int k = 1; k <= 12; k++) begin
            step();
            check_out("own1 dwell", 3'b010, 1'b0, PAT1);
        end
        step();
        check_out("switch to 0", 3'b001, 1'b1, PAT0_A);

        req = 3'b001;
        for (int k = 1; k <= 100; k++) begin
            step();
            check_out("sole owner", 3'b001, 1'b0, PAT0_A);
        end
        pat0 = PAT0_B;
        #1;
        check_out("pat before edge", 3'b001, 1'b0, PAT0_A);
        step();
        check_out("pat follow", 3'b001, 1'b0, PAT0_B);

        req = 3'b011;
        step();
        check_out("saturated dwell", 3'b010, 1'b1, PAT1);
        for (int k = 1; k <= 5; k++) begin
            step();
            check_out("own1 pre-urg", 3'b010, 1'b0, PAT1);
        end

        req = 3'b111;
        step();
        check_out("urg entry", 3'b100, 1'b1, PAT2);
        for (int k = 1; k < 24; k++) begin
            step();
            check_out("blink", 3'b100, 1'b0, (((k / 8) % 2) == 0) ? PAT2 : 32'h0);
        end

        req = 3'b011;
        step();
        check_out("urg exit ptr", 3'b001, 1'b1, PAT0_B);

        req = 3'b000;
        step();
        check_out("owner drop idle", 3'b000, 1'b1, 32'h0);
        step();
        check_out("idle hold", 3'b000, 1'b0, 32'h0);

        req = 3'b010;
        step();
        check_out("idle to own1", 3'b010, 1'b1, PAT1);
        req = 3'b001;
        step();
        check_out("handover", 3'b001, 1'b1, PAT0_B);

        req = 3'b011;
        for (int k = 1; k <= 12; k++) begin
            step();
            check_out("own0 contention", 3'b001, 1'b0, PAT0_B);
        end
        req = 3'b111;
        step();
        check_out("urg beats dwell", 3'b100, 1'b1, PAT2);

        #2;
        rst = 1'b1;
        #1;
        check_out("async reset", 3'b000, 1'b0, 32'h0);
        req = 3'b011;
        step();
        check_out("reset hold", 3'b000, 1'b0, 32'h0);
        rst = 1'b0;
        step();
        check_out("restart ptr", 3'b001, 1'b1, PAT0_B);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
